stage_mem: RTL and testbench

STAGE_MEM -- requirements
Module: stage_mem

---
 rtl/stage_mem.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_stage_mem.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// MEM pipeline stage: EX/MEM register, data-bus request FSM with timeout,
// store lane steering, load extraction/extension and access-fault trapping.

package stage_mem_pkg;
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } memaccess_t;

    typedef enum logic [1:0] {
        TRAP_NONE   = 2'd0,
        TRAP_ENTER  = 2'd1,
        TRAP_RETURN = 2'd2
    } trap_mode_t;

    localparam logic [3:0] CAUSE_LOAD_ACCESS_FAULT  = 4'd5;
    localparam logic [3:0] CAUSE_STORE_ACCESS_FAULT = 4'd7;

    // funct3[1:0] is the mask mode (byte/half/word), funct3[2] marks unsigned loads
    typedef struct packed {
        memaccess_t memaccess;
        logic [2:0] funct3;
        logic       regwrite;
        logic       memtoreg;
    } control_signal_t;

    typedef struct packed {
        logic        valid;
        trap_mode_t  mode;
        logic [3:0]  cause;
        logic [31:0] pc;
        logic [31:0] tval;
    } trap_req_t;
endpackage

module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            start,
    input  control_signal_t control_signal_e,
    input  logic [31:0]     pc_e,
    input  logic [31:0]     pcplus4_e,
    input  logic [4:0]      rd_e,
    input  logic [31:0]     aluresult_e,
    input  logic [31:0]     storedata_e,
    input  logic [31:0]     csr_wdata_e,
    input  trap_req_t       trap_req_e,
    input  logic            flush_m,
    input  logic            hold_m,
    output control_signal_t control_signal_m,
    output logic [31:0]     pcplus4_m,
    output logic [4:0]      rd_m,
    output logic [31:0]     aluresult_m,
    output logic [31:0]     csr_wdata_m,
    output logic [31:0]     result_m,
    output logic [31:0]     readdata_m,
    output logic            memvalid_m,
    output logic            stall_req_m,
    output trap_req_t       trap_req_m,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [31:0]     dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [31:0]     dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic            dmem_err,
    input  logic [31:0]     dmem_rdata
);

    localparam int CNT_W = (BUS_TIMEOUT > 255) ? $clog2(BUS_TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(BUS_TIMEOUT);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} state_t;

    control_signal_t ctrl_q, ctrl_d;
    trap_req_t       trap_q, trap_d;
    logic [31:0]     pc_q, pc_d, pcplus4_q, pcplus4_d, alu_q, alu_d;
    logic [31:0]     store_q, store_d, csr_q, csr_d, rdata_q, rdata_d;
    logic [4:0]      rd_q, rd_d;
    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;          // current op already finished or abandoned
    logic            drain_gnt_q, drain_gnt_d; // drain still owes a grant

    logic        mem_op_s, new_op_s, is_load_s, timeout_s;
    logic        req_s, stall_s, complete_s, fault_s, load_ok_s, load_en_s;
    logic [1:0]  byte_off_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s, shifted_s, ext_s;
    logic [CNT_W-1:0] cnt_sat_s;

    // Decode the registered op: lane steering for stores, extraction for loads
    always_comb begin
        mem_op_s   = ((ctrl_q.memaccess == MEM_READ) || (ctrl_q.memaccess == MEM_WRITE))
                     && !trap_q.valid;
        new_op_s   = mem_op_s && !done_q;
        is_load_s  = (ctrl_q.memaccess == MEM_READ);
        byte_off_s = alu_q[1:0];
        timeout_s  = (cnt_q >= CNT_LIMIT);
        cnt_sat_s  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        shifted_s  = dmem_rdata >> {byte_off_s, 3'b000};
        be_s       = 4'hF;
        wdata_s    = store_q;
        if (!is_load_s) begin
            case (ctrl_q.funct3[1:0])
                2'b00: begin
                    be_s    = 4'b0001 << byte_off_s;
                    wdata_s = {4{store_q[7:0]}};
                end
                2'b01: begin
                    be_s    = 4'b0011 << byte_off_s;
                    wdata_s = {2{store_q[15:0]}};
                end
                default: begin
                    be_s    = 4'hF;
                    wdata_s = store_q;
                end
            endcase
        end else begin
            be_s    = 4'hF;
            wdata_s = store_q;
        end
        case (ctrl_q.funct3)
            3'b000:  ext_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b001:  ext_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b100:  ext_s = {24'd0, shifted_s[7:0]};
            3'b101:  ext_s = {16'd0, shifted_s[15:0]};
            default: ext_s = dmem_rdata;
        endcase
    end

    // Bus FSM next state, stall/completion, and EX/MEM register next values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        drain_gnt_d = drain_gnt_q;
        req_s       = 1'b0;
        stall_s     = 1'b0;
        complete_s  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d       = '0;
                drain_gnt_d = 1'b0;
                if (new_op_s) begin
                    req_s   = 1'b1;
                    stall_s = 1'b1;
                    if (flush_m) begin
                        state_d     = DRAIN;
                        done_d      = 1'b1;
                        drain_gnt_d = !dmem_gnt;
                    end else if (dmem_gnt) begin
                        state_d = WAIT;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                req_s = 1'b1;
                cnt_d = cnt_sat_s;
                if (timeout_s) begin
                    complete_s = 1'b1;
                    state_d    = IDLE;
                end else if (flush_m) begin
                    stall_s     = 1'b1;
                    state_d     = DRAIN;
                    done_d      = 1'b1;
                    drain_gnt_d = !dmem_gnt;
                end else if (dmem_gnt) begin
                    stall_s = 1'b1;
                    state_d = WAIT;
                end else begin
                    stall_s = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_sat_s;
                if (dmem_rvalid || timeout_s) begin
                    complete_s = 1'b1;
                    state_d    = IDLE;
                end else if (flush_m) begin
                    stall_s     = 1'b1;
                    state_d     = DRAIN;
                    done_d      = 1'b1;
                    drain_gnt_d = 1'b0;
                end else begin
                    stall_s = 1'b1;
                end
            end
            DRAIN: begin
                // Keep the request up until the slave accepts it, then swallow the response
                stall_s = 1'b1;
                req_s   = drain_gnt_q;
                cnt_d   = cnt_sat_s;
                if (timeout_s) begin
                    state_d = IDLE;
                end else if (drain_gnt_q) begin
                    drain_gnt_d = !dmem_gnt;
                end else if (dmem_rvalid) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        fault_s   = complete_s && (timeout_s || (dmem_rvalid && dmem_err));
        load_ok_s = complete_s && is_load_s && !fault_s;
        rdata_d   = load_ok_s ? ext_s : rdata_q;
        if (complete_s) begin
            done_d = 1'b1;
        end else begin
            done_d = done_d;
        end

        ctrl_d    = ctrl_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        rd_d      = rd_q;
        alu_d     = alu_q;
        store_d   = store_q;
        csr_d     = csr_q;
        trap_d    = trap_q;
        load_en_s = !stall_s && (flush_m || !hold_m);
        if (load_en_s) begin
            done_d = 1'b0;
            if (flush_m) begin
                ctrl_d    = '0;
                pc_d      = 32'd0;
                pcplus4_d = 32'd0;
                rd_d      = 5'd0;
                alu_d     = 32'd0;
                store_d   = 32'd0;
                csr_d     = 32'd0;
                trap_d    = '0;
            end else begin
                ctrl_d    = control_signal_e;
                pc_d      = pc_e;
                pcplus4_d = pcplus4_e;
                rd_d      = rd_e;
                alu_d     = aluresult_e;
                store_d   = storedata_e;
                csr_d     = csr_wdata_e;
                trap_d    = trap_req_e;
            end
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // All stage state: pipeline register, FSM, wait counter and load data
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            ctrl_q      <= '0;
            pc_q        <= 32'd0;
            pcplus4_q   <= 32'd0;
            rd_q        <= 5'd0;
            alu_q       <= 32'd0;
            store_q     <= 32'd0;
            csr_q       <= 32'd0;
            trap_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            drain_gnt_q <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
            pcplus4_q   <= pcplus4_d;
            rd_q        <= rd_d;
            alu_q       <= alu_d;
            store_q     <= store_d;
            csr_q       <= csr_d;
            trap_q      <= trap_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            drain_gnt_q <= drain_gnt_d;
            rdata_q     <= rdata_d;
        end
    end

    // Trap output: a bus fault in the completion cycle, otherwise the carried EX trap
    always_comb begin
        trap_req_m = trap_q;
        if (fault_s) begin
            trap_req_m.valid = 1'b1;
            trap_req_m.mode  = TRAP_ENTER;
            trap_req_m.cause = is_load_s ? CAUSE_LOAD_ACCESS_FAULT : CAUSE_STORE_ACCESS_FAULT;
            trap_req_m.pc    = pc_q;
            trap_req_m.tval  = alu_q;
        end else begin
            trap_req_m = trap_q;
        end
    end

    assign control_signal_m = ctrl_q;
    assign pcplus4_m        = pcplus4_q;
    assign rd_m             = rd_q;
    assign aluresult_m      = alu_q;
    assign csr_wdata_m      = csr_q;
    assign result_m         = alu_q;
    assign readdata_m       = rdata_d;
    assign memvalid_m       = load_ok_s;
    assign stall_req_m      = stall_s;
    assign dmem_req         = req_s;
    assign dmem_we          = req_s && (ctrl_q.memaccess == MEM_WRITE);
    assign dmem_addr        = {alu_q[31:2], 2'b00};
    assign dmem_be          = req_s ? be_s : 4'h0;
    assign dmem_wdata       = wdata_s;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: loads, stores, wait states, faults, drain, reset.
module tb_stage_mem;
    import stage_mem_pkg::*;

    logic            clk = 1'b0;
    logic            start;
    control_signal_t control_signal_e, control_signal_m;
    logic [31:0]     pc_e, pcplus4_e, aluresult_e, storedata_e, csr_wdata_e;
    logic [4:0]      rd_e, rd_m;
    trap_req_t       trap_req_e, trap_req_m;
    logic            flush_m, hold_m;
    logic [31:0]     pcplus4_m, aluresult_m, csr_wdata_m, result_m, readdata_m;
    logic            memvalid_m, stall_req_m;
    logic            dmem_req, dmem_we, dmem_gnt, dmem_rvalid, dmem_err;
    logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]      dmem_be;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stage_mem dut (
        .clk(clk), .start(start),
        .control_signal_e(control_signal_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e),
        .rd_e(rd_e), .aluresult_e(aluresult_e), .storedata_e(storedata_e),
        .csr_wdata_e(csr_wdata_e), .trap_req_e(trap_req_e),
        .flush_m(flush_m), .hold_m(hold_m),
        .control_signal_m(control_signal_m), .pcplus4_m(pcplus4_m), .rd_m(rd_m),
        .aluresult_m(aluresult_m), .csr_wdata_m(csr_wdata_m), .result_m(result_m),
        .readdata_m(readdata_m), .memvalid_m(memvalid_m), .stall_req_m(stall_req_m),
        .trap_req_m(trap_req_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_err(dmem_err), .dmem_rdata(dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input memaccess_t ma, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd);
        control_signal_e           = '0;
        control_signal_e.memaccess = ma;
        control_signal_e.funct3    = f3;
        control_signal_e.regwrite  = (ma == MEM_READ);
        control_signal_e.memtoreg  = (ma == MEM_READ);
        aluresult_e = addr;
        storedata_e = sd;
        pc_e        = 32'h8000_0000 + addr;
        pcplus4_e   = 32'h8000_0004 + addr;
        rd_e        = 5'd10;
        csr_wdata_e = 32'd0;
        trap_req_e  = '0;
    endtask

    task automatic nop();
        set_ex(MEM_NONE, 3'b000, 32'd0, 32'd0);
    endtask

    task automatic bus(input logic g, input logic rv, input logic er, input logic [31:0] rd);
        dmem_gnt = g; dmem_rvalid = rv; dmem_err = er; dmem_rdata = rd;
    endtask

    // The bus contract forbids grant and response in the same cycle
    task automatic tick();
        if (dmem_gnt && dmem_rvalid) begin
            n_fail++;
            $error("FAIL bus_contract: gnt=%b rvalid=%b, required not both", dmem_gnt, dmem_rvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  stall_drop;

        start = 1'b0; flush_m = 1'b0; hold_m = 1'b0;
        set_ex(MEM_READ, 3'b010, 32'h100, 32'd0);
        bus(1'b0, 1'b0, 1'b0, 32'd0);
        // reset state
        smp();
        chk("rst_req",    {31'd0, dmem_req}, 32'd0);
        chk("rst_we",     {31'd0, dmem_we}, 32'd0);
        chk("rst_be",     {28'd0, dmem_be}, 32'd0);
        chk("rst_stall",  {31'd0, stall_req_m}, 32'd0);
        chk("rst_mvalid", {31'd0, memvalid_m}, 32'd0);
        chk("rst_rdata",  readdata_m, 32'd0);
        chk("rst_alu",    aluresult_m, 32'd0);
        chk("rst_trap",   {31'd0, trap_req_m.valid}, 32'd0);
        tick();
        start = 1'b1;
        nop();
        tick();

        // register load, hold, flush-over-hold
        set_ex(MEM_NONE, 3'b000, 32'h55, 32'd0);
        csr_wdata_e = 32'hC5;
        tick(); smp();
        chk("reg_alu",     aluresult_m, 32'h55);
        chk("reg_result",  result_m, 32'h55);
        chk("reg_pc4",     pcplus4_m, 32'h8000_0059);
        chk("reg_rd",      {27'd0, rd_m}, 32'd10);
        chk("reg_csr",     csr_wdata_m, 32'hC5);
        set_ex(MEM_NONE, 3'b000, 32'h66, 32'd0);
        hold_m = 1'b1;
        tick(); smp();
        chk("hold_alu", aluresult_m, 32'h55);
        flush_m = 1'b1;
        tick(); smp();
        chk("flush_alu", aluresult_m, 32'd0);
        chk("flush_pc4", pcplus4_m, 32'd0);
        flush_m = 1'b0; hold_m = 1'b0; nop();
        tick();

        // LW 0x100, gnt cycle 0, rvalid cycle 1
        set_ex(MEM_READ, 3'b010, 32'h100, 32'd0); tick();
        nop(); bus(1'b1, 1'b0, 1'b0, 32'd0); smp();
        chk("lw_req",   {31'd0, dmem_req}, 32'd1);
        chk("lw_addr",  dmem_addr, 32'h100);
        chk("lw_be",    {28'd0, dmem_be}, 32'hF);
        chk("lw_we",    {31'd0, dmem_we}, 32'd0);
        chk("lw_stall0", {31'd0, stall_req_m}, 32'd1);
        tick();
        bus(1'b0, 1'b1, 1'b0, 32'hDEADBEEF); smp();
        chk("lw_stall1", {31'd0, stall_req_m}, 32'd0);
        chk("lw_mvalid", {31'd0, memvalid_m}, 32'd1);
        chk("lw_data",   readdata_m, 32'hDEADBEEF);
        tick();
        bus(1'b0, 1'b0, 1'b0, 32'd0); smp();
        chk("lw_mvalid_off", {31'd0, memvalid_m}, 32'd0);
        chk("lw_data_hold",  readdata_m, 32'hDEADBEEF);

        // SB 0x203, data 0xA5
        set_ex(MEM_WRITE, 3'b000, 32'h203, 32'h0000_00A5); tick();
        nop(); bus(1'b1, 1'b0, 1'b0, 32'd0); smp();
        chk("sb_we",    {31'd0, dmem_we}, 32'd1);
        chk("sb_addr",  dmem_addr, 32'h200);
        chk("sb_be",    {28'd0, dmem_be}, 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        tick();
        bus(1'b0, 1'b1, 1'b0, 32'd0); smp();
        chk("sb_stall",  {31'd0, stall_req_m}, 32'd0);
        chk("sb_mvalid", {31'd0, memvalid_m}, 32'd0);
        chk("sb_rdata",  readdata_m, 32'hDEADBEEF);
        tick(); bus(1'b0, 1'b0, 1'b0, 32'd0);

        // LH / LHU at 0x102, upper half 0x8001
        set_ex(MEM_READ, 3'b001, 32'h102, 32'd0); tick();
        nop(); bus(1'b1, 1'b0, 1'b0, 32'd0); smp();
        chk("lh_be", {28'd0, dmem_be}, 32'hF);
        tick();
        bus(1'b0, 1'b1, 1'b0, 32'h8001_1234); smp();
        chk("lh_data", readdata_m, 32'hFFFF8001);
        tick(); bus(1'b0, 1'b0, 1'b0, 32'd0);
        set_ex(MEM_READ, 3'b101, 32'h102, 32'd0); tick();
        nop(); bus(1'b1, 1'b0, 1'b0, 32'd0); smp(); tick();
        bus(1'b0, 1'b1, 1'b0, 32'h8001_1234); smp();
        chk("lhu_data", readdata_m, 32'h00008001);
        tick(); bus(1'b0, 1'b0, 1'b0, 32'd0);

        // grant withheld for three cycles
        set_ex(MEM_READ, 3'b010, 32'h344, 32'd0); tick();
        nop();
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("wt_req",   {31'd0, dmem_req}, 32'd1);
            chk("wt_addr",  dmem_addr, 32'h344);
            chk("wt_be",    {28'd0, dmem_be}, 32'hF);
            chk("wt_stall", {31'd0, stall_req_m}, 32'd1);
            tick();
        end
        bus(1'b1, 1'b0, 1'b0, 32'd0); smp();
        chk("wt_gnt_req",   {31'd0, dmem_req}, 32'd1);
        chk("wt_gnt_stall", {31'd0, stall_req_m}, 32'd1);
        tick();
        bus(1'b0, 1'b1, 1'b0, 32'h12345678); smp();
        chk("wt_done_stall", {31'd0, stall_req_m}, 32'd0);
        chk("wt_data",       readdata_m, 32'h12345678);
        tick(); bus(1'b0, 1'b0, 1'b0, 32'd0);

        // load access fault
        set_ex(MEM_READ, 3'b010, 32'h300, 32'd0); tick();
        nop(); bus(1'b1, 1'b0, 1'b0, 32'd0); smp(); tick();
        bus(1'b0, 1'b1, 1'b1, 32'hFFFF_0000); smp();
        chk("lerr_valid",  {31'd0, trap_req_m.valid}, 32'd1);
        chk("lerr_mode",   {30'd0, trap_req_m.mode}, 32'd1);
        chk("lerr_cause",  {28'd0, trap_req_m.cause}, 32'd5);
        chk("lerr_tval",   trap_req_m.tval, 32'h300);
        chk("lerr_pc",     trap_req_m.pc, 32'h8000_0300);
        chk("lerr_mvalid", {31'd0, memvalid_m}, 32'd0);
        chk("lerr_rdata",  readdata_m, 32'h12345678);
        tick(); bus(1'b0, 1'b0, 1'b0, 32'd0); smp();
        chk("lerr_clear", {31'd0, trap_req_m.valid}, 32'd0);

        // store access fault
        set_ex(MEM_WRITE, 3'b010, 32'h400, 32'h1111_2222); tick();
        nop(); bus(1'b1, 1'b0, 1'b0, 32'd0); smp();
        chk("sw_be", {28'd0, dmem_be}, 32'hF);
        tick();
        bus(1'b0, 1'b1, 1'b1, 32'd0); smp();
        chk("serr_cause", {28'd0, trap_req_m.cause}, 32'd7);
        chk("serr_tval",  trap_req_m.tval, 32'h400);
        tick(); bus(1'b0, 1'b0, 1'b0, 32'd0);

        // no response at all: timeout after BUS_TIMEOUT cycles in REQ
        set_ex(MEM_READ, 3'b010, 32'h304, 32'd0); tick();
        nop();
        n = 0; seen = 1'b0; stall_drop = 1'b0;
        while (!seen && n < 400) begin
            smp();
            if (trap_req_m.valid) begin
                seen = 1'b1;
            end else begin
                if (!stall_req_m) stall_drop = 1'b1;
                tick();
                n++;
            end
        end
        chk("to_cycles",  n, 32'd256);
        chk("to_stall_held", {31'd0, stall_drop}, 32'd0);
        chk("to_cause",   {28'd0, trap_req_m.cause}, 32'd5);
        chk("to_tval",    trap_req_m.tval, 32'h304);
        chk("to_stall",   {31'd0, stall_req_m}, 32'd0);
        tick();

        // flush during WAIT -> drain, response dropped
        set_ex(MEM_READ, 3'b010, 32'h500, 32'd0); tick();
        nop(); bus(1'b1, 1'b0, 1'b0, 32'd0); smp(); tick();
        bus(1'b0, 1'b0, 1'b0, 32'd0); flush_m = 1'b1; smp();
        chk("dr_stall_w", {31'd0, stall_req_m}, 32'd1);
        tick();
        flush_m = 1'b0; smp();
        chk("dr_stall_d", {31'd0, stall_req_m}, 32'd1);
        chk("dr_req",     {31'd0, dmem_req}, 32'd0);
        tick();
        bus(1'b0, 1'b1, 1'b0, 32'hCAFEF00D); smp();
        chk("dr_mvalid",  {31'd0, memvalid_m}, 32'd0);
        chk("dr_stall_r", {31'd0, stall_req_m}, 32'd1);
        chk("dr_rdata",   readdata_m, 32'h12345678);
        tick();
        bus(1'b0, 1'b0, 1'b0, 32'd0); smp();
        chk("dr_stall_end", {31'd0, stall_req_m}, 32'd0);
        chk("dr_no_reissue", {31'd0, dmem_req}, 32'd0);
        tick();

        // registered EX trap suppresses the bus access
        set_ex(MEM_READ, 3'b010, 32'h700, 32'd0);
        trap_req_e.valid = 1'b1; trap_req_e.mode = TRAP_ENTER;
        trap_req_e.cause = 4'd2; trap_req_e.tval = 32'h1234;
        tick();
        nop(); smp();
        chk("tp_req",   {31'd0, dmem_req}, 32'd0);
        chk("tp_stall", {31'd0, stall_req_m}, 32'd0);
        chk("tp_valid", {31'd0, trap_req_m.valid}, 32'd1);
        chk("tp_cause", {28'd0, trap_req_m.cause}, 32'd2);
        chk("tp_tval",  trap_req_m.tval, 32'h1234);
        tick();

        // reset mid-transaction, late rvalid ignored
        set_ex(MEM_READ, 3'b010, 32'h600, 32'd0); tick();
        nop(); bus(1'b1, 1'b0, 1'b0, 32'd0); smp(); tick();
        bus(1'b0, 1'b0, 1'b0, 32'd0);
        #1 start = 1'b0;
        smp();
        chk("mr_stall", {31'd0, stall_req_m}, 32'd0);
        chk("mr_req",   {31'd0, dmem_req}, 32'd0);
        chk("mr_alu",   aluresult_m, 32'd0);
        tick();
        start = 1'b1;
        bus(1'b0, 1'b1, 1'b0, 32'hBAD0BAD0); smp();
        chk("late_mvalid", {31'd0, memvalid_m}, 32'd0);
        chk("late_rdata",  readdata_m, 32'd0);
        chk("late_stall",  {31'd0, stall_req_m}, 32'd0);
        tick();
        bus(1'b0, 1'b0, 1'b0, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
